// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: datapath width and M-extension divide opcodes.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Encodings follow funct3[1:0] of DIV/DIVU/REM/REMU (funct3 = 3'b1xx)
  typedef enum logic [1:0] {
    MD_DIV  = 2'b00,
    MD_DIVU = 2'b01,
    MD_REM  = 2'b10,
    MD_REMU = 2'b11
  } md_op_t;

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_is_rem(input md_op_t op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift {rem,quo} left, trial-subtract the divisor.
module div_step
  import riscv_pkg::*;
#(
  parameter int unsigned W = riscv_pkg::XLEN
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] rem_sh;
  logic [W:0] trial;

  // rem < divisor on entry, so rem_sh < 2*divisor and W+1 bits hold the trial's sign exactly
  always_comb begin
    rem_sh   = {rem, quo[W-1]};
    trial    = rem_sh - {1'b0, divisor};
    quo_next = {quo[W-2:0], ~trial[W]};
    rem_next = trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divide/remainder unit with start/busy/done handshake and flush abort.
module div_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  md_op_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam int unsigned CW = $clog2(XLEN);

  div_state_t      state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic            neg_q;
  logic            neg_r;
  logic            want_rem;

  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] rem_next;

  logic            op_signed;
  logic            op_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] final_res;

  div_step #(.W(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Operand decode for acceptance: magnitudes, signs and the cases that bypass iteration
  always_comb begin
    op_signed   = md_is_signed(op);
    op_rem      = md_is_rem(op);
    a_neg       = op_signed & a[XLEN-1];
    b_neg       = op_signed & b[XLEN-1];
    a_mag       = a_neg ? (~a + 1'b1) : a;
    b_mag       = b_neg ? (~b + 1'b1) : b;
    special     = 1'b0;
    special_res = '0;
    if (b == '0) begin
      special     = 1'b1;
      special_res = op_rem ? a : '1;
    end else if (op_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
      special     = 1'b1;
      special_res = op_rem ? '0 : a;
    end
  end

  always_comb begin
    final_res = '0;
    if (want_rem) final_res = neg_r ? (~rem_next + 1'b1) : rem_next;
    else          final_res = neg_q ? (~quo_next + 1'b1) : quo_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      count    <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && special) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= special_res;
          end else if (start) begin
            state    <= CALC;
            busy     <= 1'b1;
            done     <= 1'b0;
            quo      <= a_mag;
            rem      <= '0;
            dvs      <= b_mag;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            want_rem <= op_rem;
            count    <= CW'(XLEN - 1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        CALC: begin
          quo <= quo_next;
          rem <= rem_next;
          if (count == '0) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= final_res;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
